qmax_rmw_table: RTL and testbench

//  Per-state Q-max store with an internal read-compare-write max update. One update per

---
 rtl/qmax_rmw_table_if.sv | 44 ++++
 rtl/qmax_rmw_table.sv | 137 +++++++++++++
 tb/tb_qmax_rmw_table.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/qmax_rmw_table_if.sv
// qmax_rmw_table_if
//   Bundles the clear control, update handshake and read port of the Q-max table.
//   master : Q-update datapath / policy side (drives requests, observes results)
//   slave  : qmax_rmw_table
//   Signals:
//     i_clear        request full-table clear
//     o_busy         clear sweep or drain in progress
//     i_upd_valid    update request valid
//     o_upd_ready    update accepted on valid & ready at the clock edge
//     i_upd_addr     state index to update
//     i_upd_data     candidate Q value
//     o_upd_done     one-cycle pulse when an update is committed
//     o_upd_changed  qualifies o_upd_done: stored value was replaced
//     i_rd_en        read request
//     i_rd_addr      read index
//     o_rd_valid     o_rd_data valid this cycle
//     o_rd_data      registered read data
interface qmax_rmw_table_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8
);
   logic                  i_clear;
   logic                  o_busy;
   logic                  i_upd_valid;
   logic                  o_upd_ready;
   logic [ADDR_WIDTH-1:0] i_upd_addr;
   logic [DATA_WIDTH-1:0] i_upd_data;
   logic                  o_upd_done;
   logic                  o_upd_changed;
   logic                  i_rd_en;
   logic [ADDR_WIDTH-1:0] i_rd_addr;
   logic                  o_rd_valid;
   logic [DATA_WIDTH-1:0] o_rd_data;

   modport master (
      output i_clear, i_upd_valid, i_upd_addr, i_upd_data, i_rd_en, i_rd_addr,
      input  o_busy, o_upd_ready, o_upd_done, o_upd_changed, o_rd_valid, o_rd_data
   );

   modport slave (
      input  i_clear, i_upd_valid, i_upd_addr, i_upd_data, i_rd_en, i_rd_addr,
      output o_busy, o_upd_ready, o_upd_done, o_upd_changed, o_rd_valid, o_rd_data
   );
endinterface

// File: rtl/qmax_rmw_table.sv
// qmax_rmw_table
//   Per-state Q-max store. Each accepted update reads the stored value, keeps the
//   larger of stored and candidate, and writes it back one cycle later. A separate
//   registered read port serves the action-selection path. After reset, or on an
//   i_clear request, a sweep writes INIT_VAL to every entry.
//   Ports:
//     i_clk    clock, all state on rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      qmax_rmw_table_if slave modport (clear, update handshake, read port)
module qmax_rmw_table #(
   parameter int                   ADDR_WIDTH = 6,
   parameter int                   DATA_WIDTH = 8,
   parameter int                   DEPTH      = 64,
   parameter int                   SIGNED     = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL  = '0
) (
   input logic               i_clk,
   input logic               i_rst_n,
   qmax_rmw_table_if.slave   bus
);

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] sweep_ptr;
   logic                  run;
   logic                  accept;

   logic                  s1_vld;
   logic [ADDR_WIDTH-1:0] s1_addr;
   logic [DATA_WIDTH-1:0] s1_cand;
   logic [DATA_WIDTH-1:0] s1_old;
   logic [DATA_WIDTH-1:0] s1_new;
   logic                  s1_gt;

   logic                  upd_done;
   logic                  upd_changed;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return int'({1'b0, a}) < DEPTH;
   endfunction

   function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
      if (SIGNED != 0) return $signed(a) > $signed(b);
      return a > b;
   endfunction

   assign run    = (state == ST_RUN);
   assign accept = bus.i_upd_valid && bus.o_upd_ready;

   assign bus.o_upd_ready   = run && !bus.i_clear;
   assign bus.o_busy        = !run;
   assign bus.o_upd_done    = upd_done;
   assign bus.o_upd_changed = upd_changed;
   assign bus.o_rd_valid    = rd_valid;
   assign bus.o_rd_data     = rd_data;

   // S1: compare candidate against stored (or forwarded) value
   assign s1_gt  = greater(s1_cand, s1_old);
   assign s1_new = s1_gt ? s1_cand : s1_old;

   // Control: FSM, sweep pointer, pipeline valid, output flags and read port
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_CLEAR;
         sweep_ptr   <= '0;
         s1_vld      <= 1'b0;
         upd_done    <= 1'b0;
         upd_changed <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (sweep_ptr == LAST_ADDR) begin
                  state     <= ST_RUN;
                  sweep_ptr <= '0;
               end else begin
                  sweep_ptr <= sweep_ptr + 1'b1;
               end
            end
            ST_RUN: begin
               if (bus.i_clear) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // the last S1 write lands on the RUN->DRAIN edge; restart the sweep
               state     <= ST_CLEAR;
               sweep_ptr <= '0;
            end
            default: begin
               state     <= ST_CLEAR;
               sweep_ptr <= '0;
            end
         endcase

         // out-of-range updates are accepted but never enter the pipe
         s1_vld      <= accept && in_range(bus.i_upd_addr);
         upd_done    <= s1_vld;
         upd_changed <= s1_vld && s1_gt;

         if (run && bus.i_rd_en) begin
            rd_valid <= 1'b1;
            rd_data  <= in_range(bus.i_rd_addr) ? mem[bus.i_rd_addr] : '0;
         end else begin
            rd_valid <= 1'b0;
         end
      end
   end

   // S0 -> S1: capture request and fetch the stored value
   always_ff @(posedge i_clk) begin
      if (accept) begin
         s1_addr <= bus.i_upd_addr;
         s1_cand <= bus.i_upd_data;
         // the S1 write landing on this same edge is not yet visible in mem
         if (s1_vld && (s1_addr == bus.i_upd_addr)) s1_old <= s1_new;
         else if (in_range(bus.i_upd_addr))         s1_old <= mem[bus.i_upd_addr];
         else                                       s1_old <= '0;
      end
   end

   // S1 -> memory: sweep write or committed max
   always_ff @(posedge i_clk) begin
      if (state == ST_CLEAR)  mem[sweep_ptr] <= INIT_VAL;
      else if (s1_vld)        mem[s1_addr]   <= s1_new;
   end

endmodule

// File: tb/tb_qmax_rmw_table.sv
module tb_qmax_rmw_table;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   qmax_rmw_table_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus_s ();
   qmax_rmw_table_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus_u ();

   qmax_rmw_table #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DEPTH(64), .SIGNED(1), .INIT_VAL(8'h00))
      dut_s (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_s));

   qmax_rmw_table #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DEPTH(64), .SIGNED(0), .INIT_VAL(8'h00))
      dut_u (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_u));

   int checks = 0;
   int errors = 0;

   // reference model: q = logical table (all accepted updates applied in order),
   // cm = contents actually committed to memory so far
   logic [7:0] q  [64];
   logic [7:0] cm [64];
   bit         pw_vld;
   int         pw_a;
   logic [7:0] pw_d;
   bit         pw_chg;
   logic [7:0] rd_hold;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit gt(input logic [7:0] x, input logic [7:0] y, input bit sgn);
      if (sgn) return int'($signed(x)) > int'($signed(y));
      return int'(x) > int'(y);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 64; i++) begin
         q[i]  = 8'h00;
         cm[i] = 8'h00;
      end
      pw_vld = 1'b0;
   endtask

   task automatic idle_inputs();
      bus_s.i_clear = 0; bus_s.i_upd_valid = 0; bus_s.i_upd_addr = '0; bus_s.i_upd_data = '0;
      bus_s.i_rd_en = 0; bus_s.i_rd_addr = '0;
      bus_u.i_clear = 0; bus_u.i_upd_valid = 0; bus_u.i_upd_addr = '0; bus_u.i_upd_data = '0;
      bus_u.i_rd_en = 0; bus_u.i_rd_addr = '0;
   endtask

   // one RUN-state cycle on the signed table with model-based checking
   task automatic cycle(input bit uv, input int ua, input logic [7:0] ud,
                        input bit re, input int ra);
      bit         chg;
      bit         exp_done;
      bit         exp_chg;
      logic [7:0] old;
      check("ready_run", 32'(bus_s.o_upd_ready), 32'd1);
      if (re) rd_hold = cm[ra];          // read-first: value before this edge's commit
      exp_done = pw_vld;
      exp_chg  = pw_chg && pw_vld;
      if (pw_vld) cm[pw_a] = pw_d;
      pw_vld = 1'b0;
      if (uv) begin
         old = q[ua];
         chg = gt(ud, old, 1'b1);
         if (chg) q[ua] = ud;
         pw_vld = 1'b1; pw_a = ua; pw_d = q[ua]; pw_chg = chg;
      end
      bus_s.i_upd_valid = uv;
      bus_s.i_upd_addr  = ua[5:0];
      bus_s.i_upd_data  = ud;
      bus_s.i_rd_en     = re;
      bus_s.i_rd_addr   = ra[5:0];
      tick();
      check("upd_done", 32'(bus_s.o_upd_done), 32'(exp_done));
      check("upd_changed", 32'(bus_s.o_upd_changed), 32'(exp_chg));
      check("rd_valid", 32'(bus_s.o_rd_valid), 32'(re));
      check("rd_data", 32'(bus_s.o_rd_data), 32'(rd_hold));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},    32'(bus_s.o_busy), 32'd1);
      check({tag, "_ready"},   32'(bus_s.o_upd_ready), 32'd0);
      check({tag, "_done"},    32'(bus_s.o_upd_done), 32'd0);
      check({tag, "_changed"}, 32'(bus_s.o_upd_changed), 32'd0);
      check({tag, "_rdvalid"}, 32'(bus_s.o_rd_valid), 32'd0);
      check({tag, "_rddata"},  32'(bus_s.o_rd_data), 32'd0);
   endtask

   task automatic wait_sweep(input string tag, input int expected);
      int n;
      n = 0;
      while (bus_s.o_busy && n < 200) begin
         tick();
         n++;
      end
      check(tag, 32'(n), 32'(expected));
   endtask

   initial begin
      idle_inputs();
      model_clear();
      rd_hold = 8'h00;

      // reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      #1 rst_n = 1'b1;

      // test 1: sweep length and every entry initialised
      wait_sweep("t1_sweep_len", 64);
      check("t1_u_busy", 32'(bus_u.o_busy), 32'd0);
      for (int i = 0; i < 64; i++) cycle(0, 0, 8'h00, 1, i);

      // test 2: larger then smaller candidate
      cycle(1, 5, 8'd20, 0, 0);
      cycle(1, 5, 8'd12, 0, 0);
      cycle(0, 0, 8'h00, 0, 0);
      cycle(0, 0, 8'h00, 1, 5);
      check("t2_rd5", 32'(bus_s.o_rd_data), 32'd20);

      // test 3: back-to-back same-address updates
      cycle(1, 9, 8'd10, 0, 0);
      cycle(1, 9, 8'd30, 0, 0);
      cycle(1, 9, 8'd25, 0, 0);
      cycle(0, 0, 8'h00, 0, 0);
      cycle(0, 0, 8'h00, 1, 9);
      check("t3_rd9", 32'(bus_s.o_rd_data), 32'd30);

      // test 4: negative candidate on the signed table, then positive
      cycle(1, 3, 8'hFB, 0, 0);
      cycle(1, 3, 8'd7, 0, 0);
      cycle(0, 0, 8'h00, 0, 0);
      cycle(0, 0, 8'h00, 1, 3);
      check("t4_rd3", 32'(bus_s.o_rd_data), 32'd7);

      // test 4b: unsigned table must take 8'hFB over 0
      bus_u.i_upd_valid = 1; bus_u.i_upd_addr = 6'd3; bus_u.i_upd_data = 8'hFB;
      tick();
      bus_u.i_upd_valid = 0;
      tick();
      check("t4u_done", 32'(bus_u.o_upd_done), 32'd1);
      check("t4u_changed", 32'(bus_u.o_upd_changed), 32'd1);
      bus_u.i_rd_en = 1; bus_u.i_rd_addr = 6'd3;
      tick();
      bus_u.i_rd_en = 0;
      check("t4u_rdvalid", 32'(bus_u.o_rd_valid), 32'd1);
      check("t4u_rd3", 32'(bus_u.o_rd_data), 32'hFB);

      // randomized stream over a few addresses to exercise forwarding
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), 8'($urandom),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      cycle(0, 0, 8'h00, 0, 0);
      cycle(0, 0, 8'h00, 0, 0);

      // test 5: clear while an update to addr 0 sits in S1
      cycle(1, 0, 8'h7F, 0, 0);
      bus_s.i_upd_valid = 0;
      bus_s.i_clear = 1;
      #1;
      check("t5_ready_drop", 32'(bus_s.o_upd_ready), 32'd0);
      check("t5_busy_pre", 32'(bus_s.o_busy), 32'd0);
      tick();
      bus_s.i_clear = 0;
      check("t5_done", 32'(bus_s.o_upd_done), 32'd1);
      check("t5_busy_set", 32'(bus_s.o_busy), 32'd1);
      wait_sweep("t5_busy_len", 65);
      model_clear();
      cycle(0, 0, 8'h00, 1, 0);
      check("t5_rd0", 32'(bus_s.o_rd_data), 32'd0);

      // test 6: async reset in the middle of an update stream
      for (int i = 0; i < 6; i++) cycle(1, i, 8'd40 + 8'(i), 0, 0);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("t6");
      idle_inputs();
      tick();
      #1 rst_n = 1'b1;
      model_clear();
      rd_hold = 8'h00;
      wait_sweep("t6_sweep_len", 64);
      for (int i = 0; i < 64; i++) cycle(0, 0, 8'h00, 1, i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
